// File: rtl/dsp_chain_feeder.sv
// dsp_chain_feeder: skews jobs into the 4-tap DSP chain and collects results against FIFO credits.
// Optional macro DSP_FEEDER_TAG_EN carries a per-job tag alongside each result.
module dsp_chain_feeder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LATENCY    = 7,
`ifdef DSP_FEEDER_TAG_EN
  parameter int unsigned TAG_W      = 4,
`endif
  localparam int unsigned D_W       = 16,
  localparam int unsigned P_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [D_W-1:0] in_a,
  input  logic signed [D_W-1:0] in_b0,
  input  logic signed [D_W-1:0] in_b1,
  input  logic signed [D_W-1:0] in_b2,
  input  logic signed [D_W-1:0] in_b3,
`ifdef DSP_FEEDER_TAG_EN
  input  logic [TAG_W-1:0]      in_tag,
`endif
  output logic signed [D_W-1:0] a_out,
  output logic signed [D_W-1:0] b0_out,
  output logic signed [D_W-1:0] b1_out,
  output logic signed [D_W-1:0] b2_out,
  output logic signed [D_W-1:0] b3_out,
  input  logic signed [P_W-1:0] p_in,
  output logic                  res_valid,
  input  logic                  res_ready,
`ifdef DSP_FEEDER_TAG_EN
  output logic signed [P_W-1:0] res_data,
  output logic [TAG_W-1:0]      res_tag
`else
  output logic signed [P_W-1:0] res_data
`endif
);

  localparam int unsigned N_TAPS = 4;
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;

  logic                  issue;
  logic                  capture;
  logic                  pop;
  logic [CNT_W-1:0]      inflight_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LATENCY:0]      vld_q;
  logic signed [P_W-1:0] mem_q [FIFO_DEPTH];
  logic signed [D_W-1:0] in_b   [N_TAPS];
  logic signed [D_W-1:0] b_last [N_TAPS];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits cover both jobs still in the chain and results waiting in the FIFO
  assign in_ready  = (SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH);
  assign issue     = in_valid & in_ready;
  assign capture   = vld_q[LATENCY];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid & res_ready;
  assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;

  assign in_b[0] = in_b0;
  assign in_b[1] = in_b1;
  assign in_b[2] = in_b2;
  assign in_b[3] = in_b3;

  assign b0_out = b_last[0];
  assign b1_out = b_last[1];
  assign b2_out = b_last[2];
  assign b3_out = b_last[3];

  // Sample register; idle cycles drive zero so bubble products vanish
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
    end else begin
      a_out <= issue ? in_a : '0;
    end
  end

  // Lane k reaches the chain k+1 cycles after the sample, matching its tap position
  for (genvar k = 0; k < N_TAPS; k++) begin : g_lane
    logic signed [D_W-1:0] q [k+2];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < k + 2; j++) begin
          q[j] <= '0;
        end
      end else begin
        q[0] <= issue ? in_b[k] : '0;
        for (int j = 1; j < k + 2; j++) begin
          q[j] <= q[j-1];
        end
      end
    end

    assign b_last[k] = q[k+1];
  end

  // Bit 0 marks a valid sample on a_out; the top bit marks p_in holding that job's result
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[LATENCY-1:0], issue};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else if (issue && !capture) begin
      inflight_q <= inflight_q + CNT_W'(1);
    end else if (!issue && capture) begin
      inflight_q <= inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (capture && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!capture && pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= p_in;
    end
  end

`ifdef DSP_FEEDER_TAG_EN
  logic [TAG_W-1:0] tag_pipe_q [LATENCY+1];
  logic [TAG_W-1:0] tag_mem_q  [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j <= LATENCY; j++) begin
        tag_pipe_q[j] <= '0;
      end
    end else begin
      tag_pipe_q[0] <= issue ? in_tag : '0;
      for (int j = 1; j <= LATENCY; j++) begin
        tag_pipe_q[j] <= tag_pipe_q[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      tag_mem_q[wr_ptr_q] <= tag_pipe_q[LATENCY];
    end
  end

  assign res_tag = res_valid ? tag_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_dsp_chain_feeder.sv
// Bench for dsp_chain_feeder: behavioural 4-tap chain model, vector table and result scoreboard.
`timescale 1ns/1ps
module tb_dsp_chain_feeder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_a = '0, in_b0 = '0, in_b1 = '0, in_b2 = '0, in_b3 = '0;
  logic signed [15:0] a_out, b0_out, b1_out, b2_out, b3_out;
  logic signed [31:0] p_in = '0;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic signed [31:0] res_data;
`ifdef DSP_FEEDER_TAG_EN
  logic [3:0]         in_tag = '0;
  logic [3:0]         res_tag;
`endif

  dsp_chain_feeder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b0(in_b0), .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
`ifdef DSP_FEEDER_TAG_EN
    .in_tag(in_tag),
`endif
    .a_out(a_out), .b0_out(b0_out), .b1_out(b1_out), .b2_out(b2_out), .b3_out(b3_out),
    .p_in(p_in),
    .res_valid(res_valid), .res_ready(res_ready),
`ifdef DSP_FEEDER_TAG_EN
    .res_tag(res_tag),
`endif
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
  } sb_t;

  typedef struct {
    logic signed [15:0] a, b0, b1, b2, b3;
    logic [31:0]        exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  sb_t         sbq[$];
  int          acc_cnt = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic [31:0] cur_exp = '0;
  logic [3:0]  cur_tag = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%08h) expected=%0d (0x%08h) t=%0t", name, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_of(input logic signed [15:0] a, b0, b1, b2, b3);
    logic signed [31:0] s;
    s = 32'(b0) + 32'(b1) + 32'(b2) + 32'(b3);
    return 32'(s * 32'(a));
  endfunction

  // Chain model: result in cycle X pairs a from cycle X-7 with b_k from cycle X-6+k
  int                 cyc = 0;
  logic signed [15:0] h_a [64];
  logic signed [15:0] h_b [4][64];

  always @(negedge clk) begin : chain_model
    logic signed [31:0] acc;
    cyc++;
    h_a[cyc % 64]    = a_out;
    h_b[0][cyc % 64] = b0_out;
    h_b[1][cyc % 64] = b1_out;
    h_b[2][cyc % 64] = b2_out;
    h_b[3][cyc % 64] = b3_out;
    if (cyc < 8) begin
      p_in = $urandom();
    end else begin
      acc = '0;
      for (int k = 0; k < 4; k++) begin
        acc = acc + 32'(h_a[(cyc - 7) % 64]) * 32'(h_b[k][(cyc - 6 + k) % 64]);
      end
      p_in = acc;
    end
  end

  // Scoreboard: push on accept, pop and compare on result handshake
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst) begin
      sbq.delete();
      run_len = 0;
    end else begin
      if (in_valid && in_ready) begin
        e.data = cur_exp;
        e.tag  = cur_tag;
        sbq.push_back(e);
        acc_cnt++;
      end
      if (res_valid && res_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected got=%0d expected=no result t=%0t", res_data, $time);
        end else begin
          e = sbq.pop_front();
          check("sb_data", res_data, e.data);
`ifdef DSP_FEEDER_TAG_EN
          check("sb_tag", 32'(res_tag), 32'(e.tag));
`endif
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input logic signed [15:0] a, b0, b1, b2, b3,
                         input logic [31:0] exp, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a = a; in_b0 = b0; in_b1 = b1; in_b2 = b2; in_b3 = b3;
    cur_exp = exp;
    cur_tag = tag;
`ifdef DSP_FEEDER_TAG_EN
    in_tag = tag;
`endif
  endtask

  task automatic send(input logic signed [15:0] a, b0, b1, b2, b3,
                      input logic [31:0] exp, input logic [3:0] tag);
    int n;
    n = 0;
    set_job(a, b0, b1, b2, b3, exp, tag);
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 expected=1 t=%0t", $time);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    while ((sbq.size() != 0 || res_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sbq.size()), 32'd0);
  endtask

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic signed [15:0] ra, rb0, rb1, rb2, rb3;

    for (int i = 0; i < 6; i++) begin
      tbl[i].a = 16'(i + 1);
      tbl[i].b0 = 16'sd1; tbl[i].b1 = 16'sd1; tbl[i].b2 = 16'sd1; tbl[i].b3 = 16'sd1;
      tbl[i].exp = 32'(4 * (i + 1));
    end
    tbl[6].a = -16'sd2;
    tbl[6].b0 = -16'sd32768; tbl[6].b1 = 16'sd5; tbl[6].b2 = 16'sd0; tbl[6].b3 = 16'sd7;
    tbl[6].exp = 32'd65512;
    tbl[7].a = -16'sd32768;
    tbl[7].b0 = -16'sd32768; tbl[7].b1 = -16'sd32768; tbl[7].b2 = -16'sd32768; tbl[7].b3 = -16'sd32768;
    tbl[7].exp = 32'd0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_a_out", 32'(a_out), 32'd0);
    check("rst_b_out", 32'({b0_out, b1_out} | {b2_out, b3_out}), 32'd0);

    // Single job: result appears exactly in cycle E+8
    res_ready = 1'b0;
    set_job(16'sd3, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 32'd30, 4'd1);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t1_res_valid", 32'(res_valid), (i == 8) ? 32'd1 : 32'd0);
    end
    check("t1_res_data", res_data, 32'd30);
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_no_extra", 32'(res_valid), 32'd0);
    end

    // Table: back-to-back ramp then signed/wrap cases
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      set_job(tbl[i].a, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, tbl[i].exp, 4'(i));
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    drain();
    check("b2b_consecutive", 32'(max_run), 32'd8);

    // Bubbles with random coefficients and random result backpressure
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom()); rb0 = 16'($urandom()); rb1 = 16'($urandom());
      rb2 = 16'($urandom()); rb3 = 16'($urandom());
      res_ready = 1'($urandom_range(0, 1));
      send(ra, rb0, rb1, rb2, rb3, exp_of(ra, rb0, rb1, rb2, rb3), 4'(i));
      repeat ($urandom_range(0, 2)) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain();

    // Backpressure: credits run out at FIFO depth, one pop frees exactly one
    res_ready = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      set_job(16'(200 + acc_cnt - base), 16'sd1, 16'sd0, 16'sd0, 16'sd0,
              exp_of(16'(200 + acc_cnt - base), 16'sd1, 16'sd0, 16'sd0, 16'sd0), 4'(acc_cnt - base));
      tick();
    end
    check("bp_accepted", 32'(acc_cnt - base), 32'd8);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_job(16'(200 + acc_cnt - base), 16'sd1, 16'sd0, 16'sd0, 16'sd0,
              exp_of(16'(200 + acc_cnt - base), 16'sd1, 16'sd0, 16'sd0, 16'sd0), 4'(acc_cnt - base));
      tick();
    end
    check("bp_one_more", 32'(acc_cnt - base), 32'd9);
    check("bp_in_ready_again_low", 32'(in_ready), 32'd0);
    drain();

    // Reset mid-flight: three jobs discarded, nothing emitted afterwards
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_job(16'(50 + i), 16'sd2, 16'sd2, 16'sd2, 16'sd2, exp_of(16'(50 + i), 16'sd2, 16'sd2, 16'sd2, 16'sd2), 4'd3);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst_no_stale", 32'(res_valid), 32'd0);
    end

    // Tagged jobs after reset, returned in order
    set_job(16'sd5, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 32'd20, 4'd5);
    tick();
    set_job(16'sd9, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 32'd36, 4'd9);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
